// File: rtl/frogger_hazard_ctrl.sv
// Moving road/river hazards for the frog playfield: per-lane scroll offsets on a slow
// tick, registered frog collision/log status and a registered per-tile renderer query.
module frogger_hazard_ctrl #(
   parameter int unsigned c_SLOW_COUNT  = 39000000,
   parameter int unsigned c_GAME_WIDTH  = 20,
   parameter int unsigned c_ROAD_FIRST  = 8,
   parameter int unsigned c_RIVER_FIRST = 2,
   parameter logic [4*c_GAME_WIDTH-1:0] c_ROAD_PATTERN  = 80'h0F0F0_C3C30_0E0E0_33300,
   parameter logic [4*c_GAME_WIDTH-1:0] c_RIVER_PATTERN = 80'hFF000_0FFF0_F00FF_00FFF
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic [5:0] i_Frogger_X,
   input  logic [5:0] i_Frogger_Y,
   input  logic [5:0] i_Col_Count_Div,
   input  logic [5:0] i_Row_Count_Div,
   output logic       o_Collided,
   output logic       o_On_Log,
   output logic [1:0] o_Hazard_Pixel,
   output logic       o_Tick
);

   localparam int unsigned c_LANES  = 4;
   localparam int unsigned c_PAT_W  = c_LANES * c_GAME_WIDTH;
   localparam int unsigned c_IDX_W  = $clog2(c_PAT_W);
   localparam logic [4:0]  c_OFF_MAX  = 5'(c_GAME_WIDTH - 1);
   localparam logic [5:0]  c_COL_LIM  = 6'(c_GAME_WIDTH);
   localparam logic [6:0]  c_SUM_LIM  = 7'(c_GAME_WIDTH);
   localparam logic [5:0]  c_ROAD_LO  = 6'(c_ROAD_FIRST);
   localparam logic [5:0]  c_ROAD_HI  = 6'(c_ROAD_FIRST + c_LANES - 1);
   localparam logic [5:0]  c_RIVER_LO = 6'(c_RIVER_FIRST);
   localparam logic [5:0]  c_RIVER_HI = 6'(c_RIVER_FIRST + c_LANES - 1);
   localparam logic [31:0] c_CNT_LAST = 32'(c_SLOW_COUNT - 1);

   function automatic logic [4:0] off_inc(input logic [4:0] off);
      return (off == c_OFF_MAX) ? 5'd0 : off + 5'd1;
   endfunction

   function automatic logic [4:0] off_dec(input logic [4:0] off);
      return (off == 5'd0) ? c_OFF_MAX : off - 5'd1;
   endfunction

   function automatic logic [4:0] sel_off(input logic [19:0] offs, input logic [1:0] lane);
      logic [4:0] o;
      case (lane)
         2'd0:    o = offs[4:0];
         2'd1:    o = offs[9:5];
         2'd2:    o = offs[14:10];
         default: o = offs[19:15];
      endcase
      return o;
   endfunction

   // col+off never exceeds 2*width-2, so one conditional subtract replaces a modulo.
   function automatic logic lane_bit(input logic [c_PAT_W-1:0] pattern, input logic [1:0] lane,
                                     input logic [4:0] off, input logic [5:0] col);
      logic [6:0]         sum;
      logic [6:0]         idx;
      logic [c_IDX_W-1:0] bit_idx;
      logic               hit;
      sum     = {1'b0, col} + {2'b00, off};
      idx     = (sum >= c_SUM_LIM) ? sum - c_SUM_LIM : sum;
      bit_idx = c_IDX_W'(lane) * c_IDX_W'(c_GAME_WIDTH) + c_IDX_W'(idx);
      hit     = 1'b0;
      if (col < c_COL_LIM)
         hit = pattern[bit_idx];
      return hit;
   endfunction

   function automatic logic [1:0] hazard_code(input logic [5:0] col, input logic [5:0] row,
                                              input logic [19:0] road_offs,
                                              input logic [19:0] river_offs);
      logic [5:0] rel;
      logic [1:0] code;
      code = 2'd0;
      rel  = 6'd0;
      if (row >= c_ROAD_LO && row <= c_ROAD_HI) begin
         rel = row - c_ROAD_LO;
         if (lane_bit(c_ROAD_PATTERN, rel[1:0], sel_off(road_offs, rel[1:0]), col))
            code = 2'd1;
      end else if (row >= c_RIVER_LO && row <= c_RIVER_HI) begin
         rel = row - c_RIVER_LO;
         if (lane_bit(c_RIVER_PATTERN, rel[1:0], sel_off(river_offs, rel[1:0]), col))
            code = 2'd2;
      end
      return code;
   endfunction

   logic [31:0] tick_cnt_q, tick_cnt_d;
   logic        tick_q, tick_d;
   logic        wrap;

   always_comb begin
      wrap       = (tick_cnt_q == c_CNT_LAST);
      tick_cnt_d = wrap ? 32'd0 : tick_cnt_q + 32'd1;
      tick_d     = wrap;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         tick_cnt_q <= 32'd0;
         tick_q     <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
      end
   end

   logic [19:0] road_offs;
   logic [19:0] river_offs;

   // River lanes all drift left with the log carry; road lanes alternate direction.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [4:0] road_off_q, road_off_d;
      logic [4:0] river_off_q, river_off_d;
      logic [4:0] road_step;

      if ((gi % 2) == 0) begin : g_fwd
         assign road_step = off_inc(road_off_q);
      end else begin : g_rev
         assign road_step = off_dec(road_off_q);
      end

      always_comb begin
         road_off_d  = wrap ? road_step : road_off_q;
         river_off_d = wrap ? off_inc(river_off_q) : river_off_q;
      end

      always_ff @(posedge i_Clk) begin
         if (i_Reset) begin
            road_off_q  <= 5'd0;
            river_off_q <= 5'd0;
         end else begin
            road_off_q  <= road_off_d;
            river_off_q <= river_off_d;
         end
      end

      assign road_offs[gi*5 +: 5]  = road_off_q;
      assign river_offs[gi*5 +: 5] = river_off_q;
   end

   logic [1:0] frog_code;
   logic [1:0] query_code;
   logic       hit_now;
   logic       log_now;
   logic       hit_prev_q, hit_prev_d;
   logic       collided_q, collided_d;
   logic       on_log_q, on_log_d;
   logic [1:0] pixel_q, pixel_d;

   // Evaluated against current (pre-tick) offsets; a same-cycle tick is seen next cycle.
   always_comb begin
      frog_code  = hazard_code(i_Frogger_X, i_Frogger_Y, road_offs, river_offs);
      query_code = hazard_code(i_Col_Count_Div, i_Row_Count_Div, road_offs, river_offs);
      hit_now    = (frog_code == 2'd1);
      log_now    = (frog_code == 2'd2);
      collided_d = hit_now & ~hit_prev_q;
      hit_prev_d = hit_now;
      on_log_d   = log_now;
      pixel_d    = query_code;
   end

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         hit_prev_q <= 1'b0;
         collided_q <= 1'b0;
         on_log_q   <= 1'b0;
         pixel_q    <= 2'd0;
      end else begin
         hit_prev_q <= hit_prev_d;
         collided_q <= collided_d;
         on_log_q   <= on_log_d;
         pixel_q    <= pixel_d;
      end
   end

   assign o_Collided     = collided_q;
   assign o_On_Log       = on_log_q;
   assign o_Hazard_Pixel = pixel_q;
   assign o_Tick         = tick_q;

endmodule

// File: tb/tb_frogger_hazard_ctrl.sv
// Directed bench for frogger_hazard_ctrl with a 4-cycle scroll tick and small test patterns.
module tb_frogger_hazard_ctrl;

   logic       i_Clk = 1'b0;
   logic       i_Reset;
   logic [5:0] i_Frogger_X;
   logic [5:0] i_Frogger_Y;
   logic [5:0] i_Col_Count_Div;
   logic [5:0] i_Row_Count_Div;
   logic       o_Collided;
   logic       o_On_Log;
   logic [1:0] o_Hazard_Pixel;
   logic       o_Tick;

   int checks_cnt = 0;
   int errors_cnt = 0;
   int n = 0;   // clock edges since the last reset edge

   // Road: lane0 bit10, lane1 bit3, lane3 bit0. River: lane0 bit19, lane1 bit5, lane3 all logs.
   frogger_hazard_ctrl #(
      .c_SLOW_COUNT   (4),
      .c_GAME_WIDTH   (20),
      .c_ROAD_FIRST   (8),
      .c_RIVER_FIRST  (2),
      .c_ROAD_PATTERN (80'h00001_00000_00008_00400),
      .c_RIVER_PATTERN(80'hFFFFF_00000_00020_80000)
   ) dut (
      .i_Clk          (i_Clk),
      .i_Reset        (i_Reset),
      .i_Frogger_X    (i_Frogger_X),
      .i_Frogger_Y    (i_Frogger_Y),
      .i_Col_Count_Div(i_Col_Count_Div),
      .i_Row_Count_Div(i_Row_Count_Div),
      .o_Collided     (o_Collided),
      .o_On_Log       (o_On_Log),
      .o_Hazard_Pixel (o_Hazard_Pixel),
      .o_Tick         (o_Tick)
   );

   always #5 i_Clk = ~i_Clk;

   task automatic check_val(input string tag, input int obs, input int exp);
      checks_cnt++;
      if (obs != exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // Ticks land on every 4th edge after reset.
   task automatic step();
      @(posedge i_Clk);
      #1;
      n++;
      check_val($sformatf("tick_n%0d", n), int'(o_Tick), (n % 4 == 0) ? 1 : 0);
   endtask

   task automatic apply_reset(input string tag);
      i_Reset = 1'b1;
      @(posedge i_Clk);
      #1;
      i_Reset = 1'b0;
      n = 0;
      check_val({tag, "_tick"},     int'(o_Tick), 0);
      check_val({tag, "_collided"}, int'(o_Collided), 0);
      check_val({tag, "_on_log"},   int'(o_On_Log), 0);
      check_val({tag, "_pixel"},    int'(o_Hazard_Pixel), 0);
   endtask

   task automatic set_frog(input int x, input int y);
      i_Frogger_X = 6'(x);
      i_Frogger_Y = 6'(y);
   endtask

   task automatic set_query(input int col, input int row);
      i_Col_Count_Div = 6'(col);
      i_Row_Count_Div = 6'(row);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_Reset = 1'b0;
      set_frog(0, 14);
      set_query(0, 13);
      apply_reset("rst0");

      set_frog(10, 8);
      set_query(5, 3);
      step();                                   // n=1
      check_val("car_entry",      int'(o_Collided), 1);
      check_val("car_not_log",    int'(o_On_Log), 0);
      check_val("pix_river1_b5",  int'(o_Hazard_Pixel), 2);

      set_query(5, 13);
      step();                                   // n=2
      check_val("car_held_1",     int'(o_Collided), 0);
      check_val("pix_row13",      int'(o_Hazard_Pixel), 0);

      set_query(10, 8);
      step();                                   // n=3
      check_val("car_held_2",     int'(o_Collided), 0);
      check_val("pix_road0_car",  int'(o_Hazard_Pixel), 1);

      set_frog(0, 14);
      set_query(25, 5);
      step();                                   // n=4, first tick
      check_val("frog_safe_row",  int'(o_Collided), 0);
      check_val("pix_col_oob",    int'(o_Hazard_Pixel), 0);

      set_frog(4, 9);
      set_query(4, 3);
      step();                                   // n=5
      check_val("road1_wrapdown", int'(o_Collided), 1);
      check_val("pix_river_off1", int'(o_Hazard_Pixel), 2);

      set_frog(3, 9);
      set_query(19, 5);
      step();                                   // n=6
      check_val("road1_old_col",  int'(o_Collided), 0);
      check_val("pix_col19",      int'(o_Hazard_Pixel), 2);

      set_frog(0, 14);
      set_query(0, 0);
      step();
      step();                                   // n=8
      check_val("pix_row0",       int'(o_Hazard_Pixel), 0);

      set_query(3, 3);
      step();                                   // n=9
      check_val("pix_river_off2", int'(o_Hazard_Pixel), 2);

      while (n < 12) step();
      set_query(2, 3);
      step();                                   // n=13
      check_val("pix_river_off3", int'(o_Hazard_Pixel), 2);

      while (n < 76) step();                    // 19 ticks: river off 19, road even 19
      set_frog(0, 2);
      step();                                   // n=77
      check_val("log_idx19",      int'(o_On_Log), 1);
      check_val("log_no_car",     int'(o_Collided), 0);

      set_frog(0, 6);
      step();                                   // n=78
      check_val("row6_no_log",    int'(o_On_Log), 0);

      set_frog(0, 14);
      step();                                   // n=79
      check_val("row14_no_log",   int'(o_On_Log), 0);
      check_val("row14_no_car",   int'(o_Collided), 0);

      set_frog(11, 8);
      step();                                   // n=80, tick with pre-tick offsets used
      check_val("car_pretick",    int'(o_Collided), 1);

      set_frog(0, 14);
      step();                                   // n=81
      check_val("car_rearm",      int'(o_Collided), 0);

      set_frog(10, 8);
      step();                                   // n=82, road0 wrapped 19->0
      check_val("road0_wrapup",   int'(o_Collided), 1);

      set_frog(0, 5);
      set_query(0, 5);
      while (n < 87) step();                    // counter at 3, offsets nonzero
      check_val("pre_rst_log",    int'(o_On_Log), 1);
      check_val("pre_rst_pix",    int'(o_Hazard_Pixel), 2);

      set_query(5, 3);
      apply_reset("rst1");
      step();                                   // n=1, offsets back at 0
      check_val("post_rst_pix",   int'(o_Hazard_Pixel), 2);
      check_val("post_rst_log",   int'(o_On_Log), 1);
      while (n < 5) step();

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
